// File: rtl/commit_trace_checker.sv
// commit_trace_checker
//   N-lane retirement-trace checker. Each RUN cycle the per-lane commit events
//   (lane0 mem, reg, hilo; lane1 mem, reg, hilo; ...) are stamped with the
//   current cycle and packed into a circular event queue. One queued event per
//   cycle is compared against the expected-trace stream.
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start                pulse: clean (re)start into RUN
//   mem_*/reg_*/hilo_*   per-lane commit events (lane l occupies slice l)
//   exp_*                expected-trace stream; exp_ready acknowledges an entry
//   stall                queue cannot absorb a worst-case commit cycle
//   pass, fail           DONE / FAIL state
//   err_code             0 none, 1 mismatch, 2 queue overflow
//   match_count, cycle   matched events since start, current cycle stamp
//   fail_got_data, fail_exp_data  data captured at the first mismatch
module commit_trace_checker #(
   parameter int NUM_LANES  = 2,
   parameter int FIFO_DEPTH = 16,
   parameter int CYC_W      = 32,
   parameter int CNT_W      = 16,
   parameter bit CHECK_CYC  = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [NUM_LANES-1:0]    mem_we,
   input  logic [16*NUM_LANES-1:0] mem_addr,
   input  logic [32*NUM_LANES-1:0] mem_data,
   input  logic [NUM_LANES-1:0]    reg_we,
   input  logic [5*NUM_LANES-1:0]  reg_waddr,
   input  logic [32*NUM_LANES-1:0] reg_wdata,
   input  logic [NUM_LANES-1:0]    hilo_we,
   input  logic [64*NUM_LANES-1:0] hilo_data,
   input  logic                    exp_valid,
   output logic                    exp_ready,
   input  logic [1:0]              exp_kind,
   input  logic [15:0]             exp_addr,
   input  logic [63:0]             exp_data,
   input  logic [CYC_W-1:0]        exp_cycle,
   input  logic                    exp_skip,
   input  logic                    exp_last,
   output logic                    stall,
   output logic                    pass,
   output logic                    fail,
   output logic [1:0]              err_code,
   output logic [CNT_W-1:0]        match_count,
   output logic [CYC_W-1:0]        cycle,
   output logic [63:0]             fail_got_data,
   output logic [63:0]             fail_exp_data
);
   localparam int          NEV     = 3 * NUM_LANES;
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] NEV_C   = (AW+1)'(NEV);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_t;

   typedef struct packed {
      logic [1:0]       kind;
      logic [15:0]      addr;
      logic [63:0]      data;
      logic [CYC_W-1:0] cyc;
   } event_t;

   state_t        state_q, state_d;
   event_t        fifo [FIFO_DEPTH];
   event_t        head;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count_q;

   event_t        ev    [NEV];
   logic [AW-1:0] ev_wa [NEV];
   logic [NEV-1:0] ev_v;
   logic [AW:0]   n_ev;

   logic          pop, hit, ovf, push;
   logic [AW:0]   free_slots;
   logic [63:0]   exp_data_eff;

   assign head = fifo[rd_ptr];
   assign pass = (state_q == S_DONE);
   assign fail = (state_q == S_FAIL);

   // Gather this cycle's events in fixed lane order; each valid event gets the
   // next consecutive queue slot so the whole cycle is written on one edge.
   always_comb begin
      n_ev = '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
         ev[3*l]     = '{kind: 2'd2, addr: mem_addr[16*l +: 16],
                         data: {32'b0, mem_data[32*l +: 32]}, cyc: cycle};
         ev_v[3*l]   = mem_we[l];
         ev[3*l+1]   = '{kind: 2'd0, addr: {11'b0, reg_waddr[5*l +: 5]},
                         data: {32'b0, reg_wdata[32*l +: 32]}, cyc: cycle};
         ev_v[3*l+1] = reg_we[l] && (reg_waddr[5*l +: 5] != 5'd0);
         ev[3*l+2]   = '{kind: 2'd1, addr: 16'h0000,
                         data: hilo_data[64*l +: 64], cyc: cycle};
         ev_v[3*l+2] = hilo_we[l];
      end
      for (int unsigned j = 0; j < NEV; j++) begin
         ev_wa[j] = wr_ptr + n_ev[AW-1:0];
         if (ev_v[j]) n_ev = n_ev + (AW+1)'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      exp_ready  = 1'b0;
      stall      = 1'b0;
      pop        = 1'b0;
      hit        = 1'b0;
      ovf        = 1'b0;
      push       = 1'b0;
      free_slots = '0;
      exp_data_eff = (exp_kind == 2'd1) ? exp_data : {32'b0, exp_data[31:0]};
      if (state_q == S_RUN) begin
         stall = (DEPTH_C - count_q) < NEV_C;
         // A start pulse discards everything, so nothing is consumed or
         // captured in that cycle.
         pop = !start && exp_valid && (count_q != '0);
         hit = exp_skip ||
               ((head.kind == exp_kind) && (head.addr == exp_addr) &&
                (head.data == exp_data_eff) &&
                (!CHECK_CYC || (head.cyc == exp_cycle)));
         // the pop of this cycle already frees a slot for this cycle's events
         free_slots = DEPTH_C - count_q + {{AW{1'b0}}, pop};
         ovf  = !start && (n_ev > free_slots);
         push = !start && !ovf && (n_ev != '0);
         if (pop && !hit)           state_d = S_FAIL;
         else if (ovf)              state_d = S_FAIL;
         else if (pop && exp_last)  state_d = S_DONE;
      end
      exp_ready = pop;
      if (start) state_d = S_RUN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle         <= '0;
         match_count   <= '0;
         err_code      <= '0;
         fail_got_data <= '0;
         fail_exp_data <= '0;
         count_q       <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
      end else if (start) begin
         cycle         <= CYC_W'(1);
         match_count   <= '0;
         err_code      <= '0;
         fail_got_data <= '0;
         fail_exp_data <= '0;
         count_q       <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
      end else if (state_q == S_RUN) begin
         if (cycle != '1) cycle <= cycle + CYC_W'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push) wr_ptr <= wr_ptr + n_ev[AW-1:0];
         count_q <= count_q + (push ? n_ev : '0) - {{AW{1'b0}}, pop};
         if (pop && hit && (match_count != '1))
            match_count <= match_count + CNT_W'(1);
         if (pop && !hit) begin
            err_code      <= 2'd1;
            fail_got_data <= head.data;
            fail_exp_data <= exp_data_eff;
         end else if (ovf) begin
            err_code <= 2'd2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         for (int unsigned j = 0; j < NEV; j++)
            if (ev_v[j]) fifo[ev_wa[j]] <= ev[j];
      end
   end

endmodule

// File: tb/tb_commit_trace_checker.sv
// tb_commit_trace_checker
//   Directed scenarios plus randomized traffic for commit_trace_checker
//   (2 lanes, 16-entry queue, cycle-exact checking enabled). A queue-based
//   reference model predicts every output each cycle.
module tb_commit_trace_checker;
   localparam int NL    = 2;
   localparam int DEPTH = 16;
   localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAIL = 3;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [NL-1:0]    mem_we, reg_we, hilo_we;
   logic [16*NL-1:0] mem_addr;
   logic [32*NL-1:0] mem_data, reg_wdata;
   logic [5*NL-1:0]  reg_waddr;
   logic [64*NL-1:0] hilo_data;
   logic          exp_valid, exp_ready, exp_skip, exp_last;
   logic [1:0]    exp_kind, err_code;
   logic [15:0]   exp_addr, match_count;
   logic [63:0]   exp_data, fail_got_data, fail_exp_data;
   logic [31:0]   exp_cycle, cycle;
   logic          stall, pass, fail;

   commit_trace_checker #(
      .NUM_LANES(NL), .FIFO_DEPTH(DEPTH), .CYC_W(32), .CNT_W(16), .CHECK_CYC(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .hilo_we(hilo_we), .hilo_data(hilo_data),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind),
      .exp_addr(exp_addr), .exp_data(exp_data), .exp_cycle(exp_cycle),
      .exp_skip(exp_skip), .exp_last(exp_last),
      .stall(stall), .pass(pass), .fail(fail), .err_code(err_code),
      .match_count(match_count), .cycle(cycle),
      .fail_got_data(fail_got_data), .fail_exp_data(fail_exp_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  kind;
      logic [15:0] addr;
      logic [63:0] data;
      logic [31:0] cyc;
   } ev_t;

   ev_t         mq[$];
   int          m_mode;
   logic [31:0] m_cycle;
   int          m_matches, m_err;
   logic [63:0] m_got, m_exp;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      mq.delete();
      m_mode = M_IDLE; m_cycle = '0; m_matches = 0; m_err = 0; m_got = '0; m_exp = '0;
   endtask

   task automatic clear_inputs();
      start = 1'b0; mem_we = '0; reg_we = '0; hilo_we = '0;
      mem_addr = '0; mem_data = '0; reg_waddr = '0; reg_wdata = '0; hilo_data = '0;
      exp_valid = 1'b0; exp_kind = '0; exp_addr = '0; exp_data = '0; exp_cycle = '0;
      exp_skip = 1'b0; exp_last = 1'b0;
   endtask

   // Present the oldest event the model holds as the expected entry.
   task automatic set_exp_head(input bit last);
      exp_valid = 1'b1; exp_skip = 1'b0; exp_last = last;
      if (mq.size() > 0) begin
         exp_kind = mq[0].kind; exp_addr = mq[0].addr;
         exp_data = mq[0].data; exp_cycle = mq[0].cyc;
      end
   endtask

   // Called at posedge+1 with inputs set: checks outputs at the falling edge,
   // advances the model, and returns at the next posedge+1.
   task automatic cycle_step();
      ev_t new_ev[$];
      ev_t e, h;
      bit ready_exp, mism;
      logic [63:0] exp_eff;
      @(negedge clk);
      ready_exp = (m_mode == M_RUN) && !start && (mq.size() > 0) && exp_valid;
      check("exp_ready", exp_ready, ready_exp);
      check("stall", stall, (m_mode == M_RUN) && (DEPTH - mq.size() < 3*NL));
      check("pass", pass, m_mode == M_DONE);
      check("fail", fail, m_mode == M_FAIL);
      check("err_code", err_code, m_err);
      check("match_count", match_count, m_matches);
      check("cycle", cycle, m_cycle);
      check("fail_got_data", fail_got_data, m_got);
      check("fail_exp_data", fail_exp_data, m_exp);
      if (start) begin
         mq.delete();
         m_mode = M_RUN; m_cycle = 32'd1; m_matches = 0; m_err = 0; m_got = '0; m_exp = '0;
      end else if (m_mode == M_RUN) begin
         for (int l = 0; l < NL; l++) begin
            if (mem_we[l]) begin
               e.kind = 2'd2; e.addr = mem_addr[16*l +: 16];
               e.data = {32'b0, mem_data[32*l +: 32]}; e.cyc = m_cycle;
               new_ev.push_back(e);
            end
            if (reg_we[l] && reg_waddr[5*l +: 5] != 5'd0) begin
               e.kind = 2'd0; e.addr = {11'b0, reg_waddr[5*l +: 5]};
               e.data = {32'b0, reg_wdata[32*l +: 32]}; e.cyc = m_cycle;
               new_ev.push_back(e);
            end
            if (hilo_we[l]) begin
               e.kind = 2'd1; e.addr = 16'h0; e.data = hilo_data[64*l +: 64]; e.cyc = m_cycle;
               new_ev.push_back(e);
            end
         end
         mism = 1'b0;
         if (ready_exp) begin
            h = mq.pop_front();
            exp_eff = (exp_kind == 2'd1) ? exp_data : {32'b0, exp_data[31:0]};
            if (exp_skip || (h.kind == exp_kind && h.addr == exp_addr &&
                             h.data == exp_eff && h.cyc == exp_cycle)) begin
               if (m_matches < 'hFFFF) m_matches++;
            end else begin
               mism = 1'b1; m_mode = M_FAIL; m_err = 1; m_got = h.data; m_exp = exp_eff;
            end
         end
         if (!mism) begin
            if (new_ev.size() > DEPTH - mq.size()) begin
               m_mode = M_FAIL; m_err = 2;
            end else begin
               foreach (new_ev[i]) mq.push_back(new_ev[i]);
               if (ready_exp && exp_last) m_mode = M_DONE;
            end
         end
         if (m_cycle != 32'hFFFF_FFFF) m_cycle++;
      end
      @(posedge clk); #1;
   endtask

   task automatic drive_random(input int ev_pct, input bit honor_stall,
                               input int bad_pct, input int last_pct);
      bit hold;
      hold = honor_stall && (m_mode == M_RUN) && (DEPTH - mq.size() < 3*NL);
      start = 1'b0;
      for (int l = 0; l < NL; l++) begin
         mem_we[l]  = !hold && ($urandom_range(99) < ev_pct);
         reg_we[l]  = !hold && ($urandom_range(99) < ev_pct);
         hilo_we[l] = !hold && ($urandom_range(99) < ev_pct);
      end
      mem_addr  = $urandom;
      mem_data  = {$urandom, $urandom};
      reg_waddr = 10'($urandom);
      reg_wdata = {$urandom, $urandom};
      hilo_data = {$urandom, $urandom, $urandom, $urandom};
      exp_valid = ($urandom_range(99) < 70);
      exp_skip  = ($urandom_range(99) < 10);
      exp_last  = ($urandom_range(99) < last_pct);
      if (mq.size() > 0) begin
         exp_kind = mq[0].kind; exp_addr = mq[0].addr;
         exp_data = mq[0].data; exp_cycle = mq[0].cyc;
         if ($urandom_range(99) < bad_pct) begin
            case ($urandom_range(2))
               0: exp_data  = exp_data ^ (64'h1 << $urandom_range(31));
               1: exp_addr  = exp_addr ^ 16'h1;
               default: exp_cycle = exp_cycle ^ 32'h1;
            endcase
         end
      end else begin
         exp_kind = 2'($urandom); exp_addr = 16'($urandom);
         exp_data = {32'b0, $urandom}; exp_cycle = $urandom;
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cycle_step();                                   // reset state

      // single reg write matched one cycle later
      start = 1'b1; cycle_step();
      clear_inputs();
      reg_we[0] = 1'b1; reg_waddr[4:0] = 5'd1; reg_wdata[31:0] = 32'h1234;
      cycle_step();
      clear_inputs(); set_exp_head(1'b1);
      #1 check("t1_exp_ready", exp_ready, 1'b1);
      cycle_step();
      clear_inputs();
      check("t1_pass", pass, 1'b1);
      check("t1_match_count", match_count, 16'd1);

      // six events in one cycle, consumed in lane order
      start = 1'b1; cycle_step();
      clear_inputs();
      mem_we = 2'b11; reg_we = 2'b11; hilo_we = 2'b11;
      mem_addr = {16'h0200, 16'h0100}; mem_data = {32'hBBBB_0001, 32'hAAAA_0001};
      reg_waddr = {5'd4, 5'd3}; reg_wdata = {32'h4444, 32'h3333};
      hilo_data = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
      cycle_step();
      for (int k = 0; k < 6; k++) begin
         clear_inputs(); set_exp_head(k == 5); cycle_step();
      end
      clear_inputs();
      check("t2_pass", pass, 1'b1);
      check("t2_match_count", match_count, 16'd6);

      // data mismatch on the third entry
      start = 1'b1; cycle_step();
      clear_inputs();
      reg_we = 2'b11; reg_waddr = {5'd2, 5'd1}; reg_wdata = {32'h2, 32'h1};
      cycle_step();
      clear_inputs();
      reg_we[0] = 1'b1; reg_waddr[4:0] = 5'd3; reg_wdata[31:0] = 32'h6;
      cycle_step();
      for (int k = 0; k < 3; k++) begin
         clear_inputs(); set_exp_head(1'b0);
         if (k == 2) exp_data = 64'h5;
         cycle_step();
      end
      clear_inputs();
      check("t3_fail", fail, 1'b1);
      check("t3_err_code", err_code, 2'd1);
      check("t3_match_count", match_count, 16'd2);
      check("t3_fail_exp_data", fail_exp_data, 64'h5);
      check("t3_fail_got_data", fail_got_data, 64'h6);

      // overflow with no expected entries, then restart
      start = 1'b1; cycle_step();
      for (int c = 0; c < 3; c++) begin
         clear_inputs();
         mem_we = 2'b11; reg_we = 2'b11; hilo_we = 2'b11; reg_waddr = {5'd9, 5'd8};
         if (c == 2) #1 check("t4_stall", stall, 1'b1);
         cycle_step();
      end
      clear_inputs();
      check("t4_err_code", err_code, 2'd2);
      start = 1'b1; cycle_step();
      clear_inputs();
      check("t4_match_count", match_count, 16'd0);
      check("t4_cycle", cycle, 32'd1);

      // cycle-exact compare: stamp 8 vs expected 7, then the same with skip
      for (int s = 0; s < 2; s++) begin
         clear_inputs(); start = 1'b1; cycle_step();
         clear_inputs();
         repeat (7) cycle_step();
         mem_we[0] = 1'b1; mem_addr[15:0] = 16'h0040; mem_data[31:0] = 32'hAB;
         cycle_step();
         clear_inputs(); set_exp_head(1'b1);
         exp_cycle = 32'd7; exp_skip = (s == 1);
         cycle_step();
         clear_inputs();
         if (s == 0) check("t5_fail", fail, 1'b1);
         else        check("t5_pass", pass, 1'b1);
      end

      // asynchronous reset with events queued
      start = 1'b1; cycle_step();
      clear_inputs();
      mem_we = 2'b11; reg_we = 2'b11; hilo_we = 2'b01; reg_waddr = {5'd6, 5'd5};
      cycle_step();
      clear_inputs(); exp_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("t6_exp_ready", exp_ready, 1'b0);
      check("t6_stall", stall, 1'b0);
      check("t6_pass", pass, 1'b0);
      check("t6_fail", fail, 1'b0);
      check("t6_err_code", err_code, 2'd0);
      check("t6_match_count", match_count, 16'd0);
      check("t6_cycle", cycle, 32'd0);
      check("t6_fail_got_data", fail_got_data, 64'd0);
      check("t6_fail_exp_data", fail_exp_data, 64'd0);
      m_reset();
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin drive_random(50, 1'b0, 0, 0); cycle_step(); end
      clear_inputs(); start = 1'b1; cycle_step();
      clear_inputs(); exp_valid = 1'b1; cycle_step();

      // randomized traffic: light load with stall honoured, then heavy load
      for (int ph = 0; ph < 2; ph++) begin
         for (int r = 0; r < 1500; r++) begin
            if (m_mode != M_RUN && $urandom_range(9) == 0) begin
               clear_inputs(); start = 1'b1; cycle_step();
            end else begin
               if (ph == 0) drive_random(30, 1'b1, 3, 2);
               else         drive_random(55, 1'b0, 1, 1);
               if ($urandom_range(399) == 0) start = 1'b1;
               cycle_step();
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
